// File: rtl/mux_2to1_pkg.sv
// Shared constants for the 2:1 mux block and its select-switch counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_2to1_pkg;

    // Default data width of I0/I1/Y/Y_q.
    localparam int MUX2_WIDTH_DEF = 1;

    // Default width of the saturating select-switch counter.
    localparam int MUX2_CNT_W_DEF = 8;

endpackage : mux_2to1_pkg

// File: rtl/mux_2to1_sw_cnt.sv
// Select-switch counter: registers the select, flags a change against the
// previous edge and counts changes, saturating at all-ones.
// Latency: 1 cycle (count updates on the edge that sees the change). Backpressure: none.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - synchronous active-low reset (clears s_q and cnt_q)
//   s_i      - select being monitored
//   sw_cnt_o - saturating count of select transitions
module mux_2to1_sw_cnt
    import mux_2to1_pkg::*;
#(
    parameter int CNT_W = MUX2_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_i,
    output logic [CNT_W-1:0] sw_cnt_o
);

    logic             s_q;
    logic             s_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             toggle;
    logic             cnt_max;

    // A transition is the current select differing from the one captured
    // at the previous edge. s_q resets to 0, so S=1 on the first edge after
    // reset release counts once.
    assign toggle  = (s_i != s_q);
    assign cnt_max = (cnt_q == {CNT_W{1'b1}});

    always_comb begin
        s_d   = s_i;
        cnt_d = cnt_q;
        // Hold at the ceiling even when a transition arrives: no wrap.
        if (toggle && !cnt_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign sw_cnt_o = cnt_q;

endmodule : mux_2to1_sw_cnt

// File: rtl/mux_2to1.sv
// 2:1 data mux with a registered copy of the selected input and a
// saturating count of select transitions.
// Latency: Y 0 cycles (1 cycle when MUX_2TO1_REG_OUT_EN is defined), Y_q 1 cycle. Backpressure: none.
//
// Build option: define MUX_2TO1_REG_OUT_EN to drive Y from Y_q instead of
// the combinational select path.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - synchronous active-low reset (Y_q, counter state)
//   I0     - data selected when S=0
//   I1     - data selected when S=1
//   S      - select
//   Y      - mux output
//   Y_q    - registered selected input
//   sw_cnt - saturating count of select transitions
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = MUX2_WIDTH_DEF,
    parameter int CNT_W = MUX2_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             S,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic [CNT_W-1:0] sw_cnt
);

    logic [WIDTH-1:0] y_sel;
    logic [WIDTH-1:0] yq_q;
    logic [WIDTH-1:0] yq_d;

    // Plain ?: keeps the standard X-merge behaviour for an unknown select:
    // bits where I0==I1 resolve, the rest go X.
    assign y_sel = S ? I1 : I0;
    assign yq_d  = y_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yq_q <= '0;
        end else begin
            yq_q <= yq_d;
        end
    end

    assign Y_q = yq_q;

`ifdef MUX_2TO1_REG_OUT_EN
    assign Y = yq_q;
`else
    // Combinational path is independent of clk and rst_n.
    assign Y = y_sel;
`endif

    mux_2to1_sw_cnt #(
        .CNT_W (CNT_W)
    ) u_sw_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_i      (S),
        .sw_cnt_o (sw_cnt)
    );

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: one 8-bit instance and one 1-bit instance
// with a 2-bit counter, driven by directed vectors.
// Latency/backpressure: n/a (testbench).
module tb_mux_2to1;

    logic       clk;
    logic       rst_a_n, rst_b_n;
    logic [7:0] i0_a, i1_a, y_a, yq_a, cnt_a;
    logic       s_a;
    logic [0:0] i0_b, i1_b, y_b, yq_b;
    logic       s_b;
    logic [1:0] cnt_b;

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_a_n), .I0(i0_a), .I1(i1_a), .S(s_a),
        .Y(y_a), .Y_q(yq_a), .sw_cnt(cnt_a)
    );

    mux_2to1 #(.WIDTH(1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_b_n), .I0(i0_b), .I1(i1_b), .S(s_b),
        .Y(y_b), .Y_q(yq_b), .sw_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         dut_b;
        logic [7:0] y;
        logic [7:0] yq;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Expected Y: the combinational select normally, the registered copy
    // when the output-register build option is on.
    function automatic logic [7:0] y_exp(input logic [7:0] comb, input logic [7:0] reg_v);
`ifdef MUX_2TO1_REG_OUT_EN
        return reg_v;
`else
        return comb;
`endif
    endfunction

    task automatic expect_a(input string name, input logic [7:0] comb,
                            input logic [7:0] yq, input logic [7:0] cnt);
        exp_t e;
        #1;
        e.name = name; e.dut_b = 1'b0;
        e.y = y_exp(comb, yq); e.yq = yq; e.cnt = cnt;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic expect_b(input string name, input logic [7:0] comb,
                            input logic [7:0] yq, input logic [7:0] cnt);
        exp_t e;
        #1;
        e.name = name; e.dut_b = 1'b1;
        e.y = y_exp(comb, yq); e.yq = yq; e.cnt = cnt;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp_v);
        end
    endtask

    // Monitor: pops each expectation the moment it is posted and compares
    // it against the DUT outputs at that instant.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            if (!e.dut_b) begin
                cmp({e.name, ".Y"},      y_a,   e.y);
                cmp({e.name, ".Y_q"},    yq_a,  e.yq);
                cmp({e.name, ".sw_cnt"}, cnt_a, e.cnt);
            end else begin
                cmp({e.name, ".Y"},      {7'd0, y_b},   e.y);
                cmp({e.name, ".Y_q"},    {7'd0, yq_b},  e.yq);
                cmp({e.name, ".sw_cnt"}, {6'd0, cnt_b}, e.cnt);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset both instances for two edges; A has S=1, I1=0xFF pending.
        rst_a_n = 1'b0; s_a = 1'b1; i0_a = 8'h00; i1_a = 8'hFF;
        rst_b_n = 1'b0; s_b = 1'b0; i0_b = 1'b1;  i1_b = 1'b0;
        edge_step();
        edge_step();
        expect_a("rst_a", 8'hFF, 8'h00, 8'h00);
        expect_b("rst_b", 8'h01, 8'h00, 8'h00);

        // Release: first edge with S=1 counts once, Y_q picks up I1.
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        edge_step();
        expect_a("rel_first", 8'hFF, 8'hFF, 8'h01);
        expect_b("rel_b_idle", 8'h01, 8'h01, 8'h00);

        // 8-bit pattern, S 0->1->0: Y switches at once, Y_q one edge later.
        i0_a = 8'hA5; i1_a = 8'h3C; s_a = 1'b0;
        expect_a("w8_s0", 8'hA5, 8'hFF, 8'h01);
        edge_step();
        expect_a("w8_s0_reg", 8'hA5, 8'hA5, 8'h02);
        s_a = 1'b1;
        expect_a("w8_s1", 8'h3C, 8'hA5, 8'h02);
        edge_step();
        expect_a("w8_s1_reg", 8'h3C, 8'h3C, 8'h03);
        s_a = 1'b0;
        expect_a("w8_s0b", 8'hA5, 8'h3C, 8'h03);
        edge_step();
        expect_a("w8_s0b_reg", 8'hA5, 8'hA5, 8'h04);

        // Reset with a transition pending: clears at the edge, Y stays live.
        s_a = 1'b1; rst_a_n = 1'b0;
        edge_step();
        expect_a("mid_rst_a", 8'h3C, 8'h00, 8'h00);
        rst_a_n = 1'b1;

        // 1-bit: S=0 -> Y=I0=1, then S=1 5 ns later -> Y=0, no edge between.
        expect_b("w1_s0", 8'h01, 8'h01, 8'h00);
        #3;
        s_b = 1'b1;
        expect_b("w1_s1_noclk", 8'h00, 8'h01, 8'h00);

        // Toggle S every edge with CNT_W=2: counts 1,2,3,3,3,3.
        begin
            logic [7:0] cnt_tab [6];
            cnt_tab[0] = 8'd1; cnt_tab[1] = 8'd2; cnt_tab[2] = 8'd3;
            cnt_tab[3] = 8'd3; cnt_tab[4] = 8'd3; cnt_tab[5] = 8'd3;
            for (int k = 0; k < 6; k++) begin
                logic [7:0] sel_v;
                // S value sampled at this edge was 1 for even k, 0 for odd k;
                // I1=0, I0=1, so Y_q = ~S.
                sel_v = (k % 2 == 0) ? 8'h00 : 8'h01;
                edge_step();
                s_b = ~s_b;
                expect_b($sformatf("sat_e%0d", k + 1), (s_b ? 8'h00 : 8'h01), sel_v, cnt_tab[k]);
            end
        end

        // Re-count to 2, then reset with a transition pending.
        rst_b_n = 1'b0;
        edge_step();
        rst_b_n = 1'b1;
        s_b = 1'b1;
        edge_step();
        s_b = 1'b0;
        edge_step();
        expect_b("pre_rst_cnt2", 8'h01, 8'h01, 8'h02);
        s_b = 1'b1; rst_b_n = 1'b0;
        edge_step();
        expect_b("mid_rst_b", 8'h00, 8'h00, 8'h00);
        rst_b_n = 1'b1;

        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux_2to1
